// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port RAM between the instruction-fetch path
//            (requester I) and the load/store path (requester D).
//            Requester D wins on contention unless fetch has been denied for
//            STARVE_LIMIT consecutive cycles, in which case fetch is forced
//            through. Read data returns one cycle after the grant and is
//            steered to whichever requester issued the read.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst_n     in   synchronous reset, ACTIVE-HIGH despite the name
//   i_req     in   fetch request valid
//   i_addr    in   fetch address                     [ADDR_W]
//   i_gnt     out  fetch request accepted this cycle
//   i_rvalid  out  fetch read data valid
//   i_rdata   out  fetch read data                   [DATA_W]
//   d_req     in   data request valid
//   d_we      in   data request is a write
//   d_addr    in   data address                      [ADDR_W]
//   d_wd      in   data write data                   [DATA_W]
//   d_gnt     out  data request accepted this cycle
//   d_rvalid  out  data read data valid (reads only)
//   d_rdata   out  data read data                    [DATA_W]
//   mem_addr  out  RAM address                       [ADDR_W]
//   mem_we    out  RAM write enable
//   mem_wd    out  RAM write data                    [DATA_W]
//   mem_rd    in   RAM read data, one cycle after the address [DATA_W]
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // RAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  // Saturation point of the 4-bit starvation counter.
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  // Owner of the read response due in the current cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_sel_e;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  rsp_sel_e   rsp_sel_q,    rsp_sel_d;

  logic       w_i_win;
  logic       w_starved;

  // --------------------------------------------------------------------------
  // Arbitration and memory-port steering
  // --------------------------------------------------------------------------
  always_comb begin
    w_starved = (starve_cnt_q == c_starve_limit);
    // Fetch wins when it is alone, or when it has been held off long enough.
    w_i_win   = i_req && (!d_req || w_starved);

    // Grants are suppressed while reset is asserted; the rest is purely
    // combinational from the requests and registered state.
    i_gnt = !rst_n && w_i_win;
    d_gnt = !rst_n && d_req && !w_i_win;

    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr = d_addr;
      mem_we   = d_we;
      mem_wd   = d_wd;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = '0;
    if (i_req && !i_gnt) begin
      starve_cnt_d = w_starved ? starve_cnt_q : (starve_cnt_q + 4'd1);
    end

    // Writes complete at grant, so only reads leave a pending response.
    rsp_sel_d = RSP_NONE;
    if (i_gnt) begin
      rsp_sel_d = RSP_I;
    end else if (d_gnt && !d_we) begin
      rsp_sel_d = RSP_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      starve_cnt_q <= '0;
      rsp_sel_q    <= RSP_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_sel_q    <= rsp_sel_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  // Gating with reset matters when reset arrives the cycle after a read
  // grant: the register still holds the pending owner, but that response
  // must be dropped.
  always_comb begin
    i_rvalid = !rst_n && (rsp_sel_q == RSP_I);
    d_rvalid = !rst_n && (rsp_sel_q == RSP_D);
    i_rdata  = i_rvalid ? mem_rd : '0;
    d_rdata  = d_rvalid ? mem_rd : '0;
  end

endmodule
`default_nettype wire
